// File: rtl/spi_pkg.sv
// Shared types and constants for the sys_clk-domain SPI responder.
package spi_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with one edge-history flop; rise/fall pulses are valid
// for one cycle, three sys_clk cycles after the pin changes.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_DEPTH{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], d_i};
      prev_q <= sync_q[SYNC_DEPTH-1];
    end
  end

  assign q_o    = sync_q[SYNC_DEPTH-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/spi_slave_sync.sv
// Oversampled SPI responder (all four modes) with a one-entry TX holding buffer
// and a one-cycle RX strobe; every output comes straight from a flop.
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter  int REG_WIDTH = 32,
  localparam int CW        = $clog2(REG_WIDTH) + 1
) (
  input  logic                 sys_clk,
  input  logic                 rstn,
  input  logic                 spi_clk,
  input  logic                 cs,
  input  logic                 mosi,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic [CW-1:0]        t_size,
  output logic                 miso,
  output logic                 miso_oe,
  input  logic [REG_WIDTH-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [REG_WIDTH-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 tx_underrun,
  output logic                 frame_err,
  output logic                 busy
);

  localparam logic [CW-1:0] RW = CW'(REG_WIDTH);

  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic cs_rise, cs_fall, cs_lvl_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk_i  (sys_clk),
    .rst_ni (rstn),
    .d_i    (spi_clk),
    .q_o    (sclk_lvl_unused),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
    .clk_i  (sys_clk),
    .rst_ni (rstn),
    .d_i    (cs),
    .q_o    (cs_lvl_unused),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk_i  (sys_clk),
    .rst_ni (rstn),
    .d_i    (mosi),
    .q_o    (mosi_s),
    .rise_o (mosi_rise_unused),
    .fall_o (mosi_fall_unused)
  );

  state_e                 state_q;
  logic                   cpol_q, cpha_q;
  logic [CW-1:0]          tsz_q;
  logic [CW-1:0]          cnt_q;
  logic [REG_WIDTH-1:0]   tx_sh_q;
  logic [REG_WIDTH-1:0]   rx_sh_q;
  logic                   pend_q;
  logic                   miso_q;
  logic                   oe_q;
  logic [REG_WIDTH-1:0]   rx_data_q;
  logic                   rx_vld_q;
  logic                   udr_q;
  logic                   ferr_q;
  logic [REG_WIDTH-1:0]   buf_q;
  logic                   buf_full_q;

  logic                   sample_edge, shift_edge;
  logic [CW-1:0]          tsz_in, tsz_use, cnt_inc;
  logic                   word_done;
  logic [REG_WIDTH-1:0]   rx_shifted;
  logic [REG_WIDTH-1:0]   cons_word, load_word;
  logic                   start, reload, consume, load;

  always_comb begin
    sample_edge = 1'b0;
    shift_edge  = 1'b0;
    case ({cpol_q, cpha_q})
      MODE0:   begin sample_edge = sclk_rise; shift_edge = sclk_fall; end
      MODE1:   begin sample_edge = sclk_fall; shift_edge = sclk_rise; end
      MODE2:   begin sample_edge = sclk_fall; shift_edge = sclk_rise; end
      MODE3:   begin sample_edge = sclk_rise; shift_edge = sclk_fall; end
      default: begin sample_edge = 1'b0;      shift_edge = 1'b0;      end
    endcase
  end

  assign tsz_in     = ((t_size == '0) || (t_size > RW)) ? RW : t_size;
  assign tsz_use    = (state_q == ST_IDLE) ? tsz_in : tsz_q;
  assign cnt_inc    = cnt_q + CW'(1);
  assign word_done  = (cnt_inc == tsz_q);
  assign rx_shifted = {rx_sh_q[REG_WIDTH-2:0], mosi_s};

  // Left-align the outgoing word so its MSB always sits at the top of tx_sh_q.
  assign cons_word  = buf_full_q ? buf_q : '0;
  assign load_word  = cons_word << (RW - tsz_use);

  // A completion coinciding with cs rising ends the frame, so nothing is consumed.
  assign start   = (state_q == ST_IDLE) & cs_fall;
  assign reload  = (state_q == ST_ACTIVE) & sample_edge & word_done & ~cs_rise;
  assign consume = start | reload;
  assign load    = tx_valid & ~buf_full_q;

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      buf_q      <= '0;
      buf_full_q <= 1'b0;
    end else begin
      if (load) buf_q <= tx_data;
      buf_full_q <= load | (buf_full_q & ~consume);
    end
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      tsz_q     <= RW;
      cnt_q     <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      pend_q    <= 1'b0;
      miso_q    <= 1'b0;
      oe_q      <= 1'b0;
      rx_data_q <= '0;
      rx_vld_q  <= 1'b0;
      udr_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_vld_q <= 1'b0;
      udr_q    <= 1'b0;
      ferr_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          miso_q <= 1'b0;
          if (cs_fall) begin
            state_q <= ST_ACTIVE;
            oe_q    <= 1'b1;
            cpol_q  <= cpol;
            cpha_q  <= cpha;
            tsz_q   <= tsz_in;
            cnt_q   <= '0;
            rx_sh_q <= '0;
            tx_sh_q <= load_word;
            udr_q   <= ~buf_full_q;
            pend_q  <= cpha;
            miso_q  <= cpha ? 1'b0 : load_word[REG_WIDTH-1];
          end
        end
        ST_ACTIVE: begin
          if (sample_edge) begin
            if (word_done) begin
              rx_data_q <= rx_shifted;
              rx_vld_q  <= 1'b1;
              cnt_q     <= '0;
              rx_sh_q   <= '0;
              pend_q    <= 1'b1;
              if (!cs_rise) begin
                tx_sh_q <= load_word;
                udr_q   <= ~buf_full_q;
              end
            end else begin
              cnt_q   <= cnt_inc;
              rx_sh_q <= rx_shifted;
            end
          end else if (shift_edge) begin
            // The first shift edge of a word presents its MSB rather than advancing.
            if (pend_q) begin
              miso_q <= tx_sh_q[REG_WIDTH-1];
              pend_q <= 1'b0;
            end else begin
              tx_sh_q <= tx_sh_q << 1;
              miso_q  <= tx_sh_q[REG_WIDTH-2];
            end
          end
          if (cs_rise) begin
            state_q <= ST_IDLE;
            oe_q    <= 1'b0;
            miso_q  <= 1'b0;
            pend_q  <= 1'b0;
            ferr_q  <= sample_edge ? ~word_done : (cnt_q != '0);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = oe_q;
  assign busy        = oe_q;
  assign tx_ready    = ~buf_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_vld_q;
  assign tx_underrun = udr_q;
  assign frame_err   = ferr_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench: a behavioural SPI master drives spi_slave_sync in all modes.
module tb_spi_slave_sync;

  localparam int H = 6;

  logic        sys_clk = 1'b0;
  logic        rstn;
  logic        spi_clk, cs, mosi, cpol, cpha;
  logic [5:0]  t_size;
  logic        miso, miso_oe, tx_ready, rx_valid, tx_underrun, frame_err, busy;
  logic [31:0] tx_data, rx_data;
  logic        tx_valid;

  int n_chk = 0, n_pass = 0;
  int rxv_cnt = 0, udr_cnt = 0, ferr_cnt = 0;
  logic [31:0] rx_q[$];

  always #5 sys_clk = ~sys_clk;

  spi_slave_sync #(.REG_WIDTH(32)) dut (
    .sys_clk     (sys_clk),
    .rstn        (rstn),
    .spi_clk     (spi_clk),
    .cs          (cs),
    .mosi        (mosi),
    .cpol        (cpol),
    .cpha        (cpha),
    .t_size      (t_size),
    .miso        (miso),
    .miso_oe     (miso_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_underrun (tx_underrun),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always @(negedge sys_clk) begin
    if (rstn) begin
      if (rx_valid) begin
        rxv_cnt++;
        rx_q.push_back(rx_data);
      end
      if (tx_underrun) udr_cnt++;
      if (frame_err) ferr_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic push_tx(input logic [31:0] d);
    int n;
    n = 0;
    @(negedge sys_clk);
    while (!tx_ready && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    check("tx_ready_wait", {31'b0, tx_ready}, 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge sys_clk);
    tx_valid = 1'b0;
  endtask

  task automatic set_mode(input logic cp, input logic ch, input logic [5:0] ts);
    cpol    = cp;
    cpha    = ch;
    t_size  = ts;
    spi_clk = cp;
    cycles(8);
  endtask

  task automatic begin_frame();
    cs = 1'b0;
    cycles(H);
  endtask

  task automatic end_frame();
    cs = 1'b1;
    cycles(8);
  endtask

  task automatic xfer_word(input logic [31:0] mo, input int nbits, output logic [31:0] mi);
    mi = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      if (!cpha) begin
        mosi = mo[i];
        cycles(H);
        spi_clk = ~cpol;
        mi = {mi[30:0], miso};
        cycles(H);
        spi_clk = cpol;
      end else begin
        spi_clk = ~cpol;
        mosi = mo[i];
        cycles(H);
        spi_clk = cpol;
        mi = {mi[30:0], miso};
      end
      cycles(H);
    end
  endtask

  logic [31:0] mi0, mi1;
  int          base_rx, base_udr, base_ferr;

  initial begin
    rstn = 1'b0; cs = 1'b1; spi_clk = 1'b0; mosi = 1'b0;
    cpol = 1'b0; cpha = 1'b0; t_size = 6'd32;
    tx_data = '0; tx_valid = 1'b0;
    cycles(3);
    check("rst miso",        {31'b0, miso},        32'd0);
    check("rst miso_oe",     {31'b0, miso_oe},     32'd0);
    check("rst busy",        {31'b0, busy},        32'd0);
    check("rst rx_data",     rx_data,              32'd0);
    check("rst rx_valid",    {31'b0, rx_valid},    32'd0);
    check("rst tx_ready",    {31'b0, tx_ready},    32'd1);
    check("rst tx_underrun", {31'b0, tx_underrun}, 32'd0);
    check("rst frame_err",   {31'b0, frame_err},   32'd0);
    rstn = 1'b1;
    cycles(4);

    // Mode 0, 32-bit word
    set_mode(1'b0, 1'b0, 6'd32);
    push_tx(32'h12345678);
    check("m0 tx_ready after load", {31'b0, tx_ready}, 32'd0);
    base_rx = rxv_cnt;
    begin_frame();
    check("m0 busy",           {31'b0, busy},     32'd1);
    check("m0 miso_oe",        {31'b0, miso_oe},  32'd1);
    check("m0 tx_ready freed", {31'b0, tx_ready}, 32'd1);
    xfer_word(32'hDEADBEEF, 32, mi0);
    end_frame();
    check("m0 rx_valid count", rxv_cnt - base_rx, 32'd1);
    check("m0 rx_data",        rx_q[$],           32'hDEADBEEF);
    check("m0 master rx",      mi0,               32'h12345678);
    check("m0 idle busy",      {31'b0, busy},     32'd0);

    // Modes 1..3, 16-bit word
    for (int m = 1; m < 4; m++) begin
      set_mode(m[1], m[0], 6'd16);
      push_tx(32'h0000A5A5);
      base_rx = rxv_cnt;
      begin_frame();
      xfer_word(32'h0000CDEF, 16, mi0);
      end_frame();
      check($sformatf("mode%0d rx_valid count", m), rxv_cnt - base_rx, 32'd1);
      check($sformatf("mode%0d rx_data", m),        rx_q[$],           32'h0000CDEF);
      check($sformatf("mode%0d master rx", m),      mi0,               32'h0000A5A5);
    end

    // Short word: only the low 8 bits of tx_data are sent
    set_mode(1'b0, 1'b0, 6'd8);
    push_tx(32'h000001C3);
    begin_frame();
    xfer_word(32'h00000067, 8, mi0);
    end_frame();
    check("short rx_data",   rx_q[$], 32'h00000067);
    check("short master rx", mi0,     32'h000000C3);

    // t_size of 0 means full width
    set_mode(1'b1, 1'b1, 6'd0);
    push_tx(32'h89ABCDEF);
    begin_frame();
    xfer_word(32'h01234567, 32, mi0);
    end_frame();
    check("tsize0 rx_data",   rx_q[$], 32'h01234567);
    check("tsize0 master rx", mi0,     32'h89ABCDEF);

    // Back-to-back words under one cs, buffer kept topped up
    set_mode(1'b0, 1'b0, 6'd32);
    push_tx(32'h11111111);
    base_rx = rxv_cnt; base_udr = udr_cnt; base_ferr = ferr_cnt;
    begin_frame();
    fork
      begin
        xfer_word(32'h0BADF00D, 32, mi0);
        xfer_word(32'hCAFEF00D, 32, mi1);
      end
      begin
        push_tx(32'h22222222);
        push_tx(32'h33333333);
      end
    join
    end_frame();
    check("b2b rx_valid count", rxv_cnt - base_rx,      32'd2);
    check("b2b rx word1",       rx_q[rx_q.size() - 2],  32'h0BADF00D);
    check("b2b rx word2",       rx_q[$],                32'hCAFEF00D);
    check("b2b master word1",   mi0,                    32'h11111111);
    check("b2b master word2",   mi1,                    32'h22222222);
    check("b2b underrun count", udr_cnt - base_udr,     32'd0);
    check("b2b frame_err count", ferr_cnt - base_ferr,  32'd0);

    // Underrun at frame start, then abort after 10 bits
    base_rx = rxv_cnt; base_udr = udr_cnt; base_ferr = ferr_cnt;
    begin_frame();
    check("udr underrun count", udr_cnt - base_udr, 32'd1);
    xfer_word(32'h000002A5, 10, mi0);
    end_frame();
    check("udr master zeros",    mi0,                 32'd0);
    check("abort frame_err",     ferr_cnt - base_ferr, 32'd1);
    check("abort rx_valid none", rxv_cnt - base_rx,    32'd0);
    check("abort rx_data kept",  rx_data,              32'hCAFEF00D);
    check("abort busy",          {31'b0, busy},        32'd0);

    // Reset mid-frame, then a clean transfer
    push_tx(32'h55AA55AA);
    begin_frame();
    xfer_word(32'h00000015, 5, mi0);
    rstn = 1'b0;
    #2;
    check("mid rst miso_oe",  {31'b0, miso_oe},  32'd0);
    check("mid rst busy",     {31'b0, busy},     32'd0);
    check("mid rst miso",     {31'b0, miso},     32'd0);
    check("mid rst rx_data",  rx_data,           32'd0);
    check("mid rst rx_valid", {31'b0, rx_valid}, 32'd0);
    check("mid rst tx_ready", {31'b0, tx_ready}, 32'd1);
    cs = 1'b1; spi_clk = 1'b0;
    cycles(3);
    rstn = 1'b1;
    cycles(6);
    set_mode(1'b0, 1'b0, 6'd32);
    push_tx(32'h12345678);
    begin_frame();
    xfer_word(32'hDEADBEEF, 32, mi0);
    end_frame();
    check("post rst rx_data",   rx_data, 32'hDEADBEEF);
    check("post rst master rx", mi0,     32'h12345678);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
